// File: rtl/frame_minmax_stats.sv
// Per-channel windowed min/max over a video frame, averaged over the last
// 2^AVG_LOG2 frames and reported two cycles after the frame's final eop.
module frame_minmax_stats #(
    parameter int unsigned W        = 8,
    parameter int unsigned CH       = 1,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned XW       = 12,
    parameter int unsigned YW       = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               valid,
    input  logic               sop,
    input  logic               eop,
    input  logic [CH*W-1:0]    data,
    input  logic               clear,
    input  logic [XW-1:0]      cfg_x_start,
    input  logic [XW-1:0]      cfg_x_end,
    input  logic [YW-1:0]      cfg_last_line,
    output logic [CH*W-1:0]    stat_min,
    output logic [CH*W-1:0]    stat_max,
    output logic [CH*W-1:0]    stat_diff,
    output logic               stat_valid
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SW    = W + AVG_LOG2;

    logic [XW-1:0] px_cnt;
    logic [XW-1:0] px_cur;
    logic [YW-1:0] line;
    logic          in_win;
    logic          frame_end;
    logic          frame_hit;
    logic          have_any;
    logic          hist_full;
    logic          pend;

    logic [W-1:0]  samp    [CH];
    logic [W-1:0]  run_min [CH];
    logic [W-1:0]  run_max [CH];
    logic [W-1:0]  fmin    [CH];
    logic [W-1:0]  fmax    [CH];
    logic [W-1:0]  hmin    [CH][DEPTH];
    logic [W-1:0]  hmax    [CH][DEPTH];
    logic [SW-1:0] sum_min [CH];
    logic [SW-1:0] sum_max [CH];
    logic [W-1:0]  avg_min [CH];
    logic [W-1:0]  avg_max [CH];

    // Beat position and frame qualification
    always_comb begin
        px_cur    = sop ? '0 : px_cnt;
        in_win    = valid && (px_cur >= cfg_x_start) && (px_cur <= cfg_x_end);
        frame_end = valid && eop && (line == cfg_last_line);
        frame_hit = frame_end && (have_any || in_win);
    end

    // Running min/max including the current beat
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            samp[c] = data[c*W +: W];
            fmin[c] = samp[c];
            fmax[c] = samp[c];
            if (have_any) begin
                fmin[c] = run_min[c];
                fmax[c] = run_max[c];
                if (in_win && (samp[c] < run_min[c])) fmin[c] = samp[c];
                if (in_win && (samp[c] > run_max[c])) fmax[c] = samp[c];
            end
        end
    end

    // History average, truncating
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            sum_min[c] = '0;
            sum_max[c] = '0;
            for (int d = 0; d < DEPTH; d++) begin
                sum_min[c] = sum_min[c] + SW'(hmin[c][d]);
                sum_max[c] = sum_max[c] + SW'(hmax[c][d]);
            end
            avg_min[c] = W'(sum_min[c] >> AVG_LOG2);
            avg_max[c] = W'(sum_max[c] >> AVG_LOG2);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            px_cnt     <= '0;
            line       <= '0;
            have_any   <= 1'b0;
            hist_full  <= 1'b0;
            pend       <= 1'b0;
            stat_valid <= 1'b0;
            stat_min   <= '0;
            stat_max   <= '0;
            stat_diff  <= '0;
            for (int c = 0; c < CH; c++) begin
                run_min[c] <= '0;
                run_max[c] <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    hmin[c][d] <= '0;
                    hmax[c][d] <= '0;
                end
            end
        end else if (clear) begin
            // Clear wins over a coincident frame end and cancels a pending update
            px_cnt     <= '0;
            line       <= '0;
            have_any   <= 1'b0;
            hist_full  <= 1'b0;
            pend       <= 1'b0;
            stat_valid <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                run_min[c] <= '0;
                run_max[c] <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    hmin[c][d] <= '0;
                    hmax[c][d] <= '0;
                end
            end
        end else begin
            pend       <= frame_hit;
            stat_valid <= pend;
            if (pend) begin
                for (int c = 0; c < CH; c++) begin
                    stat_min[c*W +: W]  <= avg_min[c];
                    stat_max[c*W +: W]  <= avg_max[c];
                    stat_diff[c*W +: W] <= avg_max[c] - avg_min[c];
                end
            end
            if (valid) begin
                px_cnt <= px_cur + XW'(1);
                if (eop) line <= (line == cfg_last_line) ? '0 : line + YW'(1);
            end
            if (in_win) begin
                have_any <= 1'b1;
                for (int c = 0; c < CH; c++) begin
                    run_min[c] <= fmin[c];
                    run_max[c] <= fmax[c];
                end
            end
            if (frame_end) have_any <= 1'b0;
            // Push the frame result; an empty history is flooded so the first average is exact
            if (frame_hit) begin
                hist_full <= 1'b1;
                for (int c = 0; c < CH; c++) begin
                    if (!hist_full) begin
                        for (int d = 0; d < DEPTH; d++) begin
                            hmin[c][d] <= fmin[c];
                            hmax[c][d] <= fmax[c];
                        end
                    end else begin
                        hmin[c][0] <= fmin[c];
                        hmax[c][0] <= fmax[c];
                        for (int d = 1; d < DEPTH; d++) begin
                            hmin[c][d] <= hmin[c][d-1];
                            hmax[c][d] <= hmax[c][d-1];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_minmax_stats.sv
// Randomized frame stimulus for frame_minmax_stats, checked against a
// frame-level model built from pixel arrays and a history list.
module tb_frame_minmax_stats;

    localparam int unsigned W = 8, CH = 2, AVG_LOG2 = 2, XW = 12, YW = 11;
    localparam int MAXL = 8;
    localparam int MAXP = 1280;
    localparam int HD   = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            valid = 1'b0, sop = 1'b0, eop = 1'b0, clear = 1'b0;
    logic [15:0]     data = '0;
    logic [XW-1:0]   cfg_x_start = '0, cfg_x_end = '0;
    logic [YW-1:0]   cfg_last_line = '0;
    logic [15:0]     stat_min, stat_max, stat_diff;
    logic            stat_valid;

    frame_minmax_stats #(.W(W), .CH(CH), .AVG_LOG2(AVG_LOG2), .XW(XW), .YW(YW)) dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .sop(sop), .eop(eop),
        .data(data), .clear(clear), .cfg_x_start(cfg_x_start), .cfg_x_end(cfg_x_end),
        .cfg_last_line(cfg_last_line), .stat_min(stat_min), .stat_max(stat_max),
        .stat_diff(stat_diff), .stat_valid(stat_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Frame content and model state
    logic [7:0]  pix [2][MAXL][MAXP];
    int          llen [MAXL];
    int          nl;
    logic [7:0]  mh_min [2][HD];
    logic [7:0]  mh_max [2][HD];
    bit          m_empty = 1'b1;
    logic [15:0] e_min = '0, e_max = '0, e_diff = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int lines, input int len, input int lo0, input int hi0,
                        input int lo1, input int hi1);
        int xs, xe;
        xs = int'(cfg_x_start);
        xe = int'(cfg_x_end);
        nl = lines;
        for (int l = 0; l < lines; l++) begin
            llen[l] = len;
            for (int i = 0; i < len; i++) begin
                if (i >= xs && i <= xe) begin
                    pix[0][l][i] = 8'($urandom_range(hi0, lo0));
                    pix[1][l][i] = 8'($urandom_range(hi1, lo1));
                end else begin
                    pix[0][l][i] = 8'($urandom);
                    pix[1][l][i] = 8'($urandom);
                end
            end
        end
        if (xs <= xe && xe < len) begin
            pix[0][0][xs] = 8'(lo0);
            pix[1][0][xs] = 8'(lo1);
            pix[0][lines-1][xe] = 8'(hi0);
            pix[1][lines-1][xe] = 8'(hi1);
        end
    endtask

    task automatic beat(input bit s, input bit e, input logic [15:0] d, input bit gaps, input bit clr);
        if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                valid = 1'b0;
                sop   = 1'($urandom);
                eop   = 1'($urandom);
                data  = 16'($urandom);
                clear = 1'b0;
                @(negedge clk);
            end
        end
        valid = 1'b1; sop = s; eop = e; data = d; clear = clr;
        @(negedge clk);
    endtask

    task automatic idle();
        valid = 1'b0; sop = 1'b0; eop = 1'b0; clear = 1'b0;
    endtask

    // Pulse must appear exactly on the second negedge after the final beat
    task automatic finish_check(input string tag, input bit expect_pulse);
        idle();
        chk({tag, "_sv_t1"}, 32'(stat_valid), 32'(1'b0));
        @(negedge clk);
        chk({tag, "_sv_t2"}, 32'(stat_valid), 32'(expect_pulse));
        chk({tag, "_min"}, 32'(stat_min), 32'(e_min));
        chk({tag, "_max"}, 32'(stat_max), 32'(e_max));
        chk({tag, "_diff"}, 32'(stat_diff), 32'(e_diff));
        @(negedge clk);
        chk({tag, "_sv_t3"}, 32'(stat_valid), 32'(1'b0));
    endtask

    task automatic model_push(input int fmn[2], input int fmx[2]);
        for (int c = 0; c < 2; c++) begin
            int smin, smax, amin, amax;
            if (m_empty) begin
                for (int d = 0; d < HD; d++) begin
                    mh_min[c][d] = 8'(fmn[c]);
                    mh_max[c][d] = 8'(fmx[c]);
                end
            end else begin
                for (int d = HD - 1; d > 0; d--) begin
                    mh_min[c][d] = mh_min[c][d-1];
                    mh_max[c][d] = mh_max[c][d-1];
                end
                mh_min[c][0] = 8'(fmn[c]);
                mh_max[c][0] = 8'(fmx[c]);
            end
            smin = 0;
            smax = 0;
            for (int d = 0; d < HD; d++) begin
                smin += int'(mh_min[c][d]);
                smax += int'(mh_max[c][d]);
            end
            amin = smin / HD;
            amax = smax / HD;
            e_min[c*8 +: 8]  = 8'(amin);
            e_max[c*8 +: 8]  = 8'(amax);
            e_diff[c*8 +: 8] = 8'(amax - amin);
        end
        m_empty = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bit gaps, input bit clr_last);
        int  fmn[2], fmx[2];
        bit  hit;
        int  xs, xe;
        xs = int'(cfg_x_start);
        xe = int'(cfg_x_end);
        hit = 1'b0;
        for (int l = 0; l < nl; l++) begin
            for (int i = 0; i < llen[l]; i++) begin
                if (i >= xs && i <= xe) begin
                    for (int c = 0; c < 2; c++) begin
                        int v;
                        v = int'(pix[c][l][i]);
                        if (!hit) begin
                            fmn[c] = v;
                            fmx[c] = v;
                        end else begin
                            if (v < fmn[c]) fmn[c] = v;
                            if (v > fmx[c]) fmx[c] = v;
                        end
                    end
                    hit = 1'b1;
                end
            end
        end
        for (int l = 0; l < nl; l++) begin
            for (int i = 0; i < llen[l]; i++) begin
                beat(i == 0, i == llen[l] - 1, {pix[1][l][i], pix[0][l][i]}, gaps,
                     clr_last && (l == nl - 1) && (i == llen[l] - 1));
            end
        end
        if (clr_last) m_empty = 1'b1;
        else if (hit) model_push(fmn, fmx);
        finish_check(tag, hit && !clr_last);
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_empty = 1'b1;
    endtask

    task automatic set_cfg(input int xs, input int xe, input int last);
        cfg_x_start   = XW'(xs);
        cfg_x_end     = XW'(xe);
        cfg_last_line = YW'(last);
    endtask

    initial begin
        set_cfg(2, 20, 2);
        repeat (2) @(negedge clk);
        chk("rst_min", 32'(stat_min), 32'(0));
        chk("rst_max", 32'(stat_max), 32'(0));
        chk("rst_diff", 32'(stat_diff), 32'(0));
        chk("rst_valid", 32'(stat_valid), 32'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Fill from empty, then averaging over four frames
        fill(3, 24, 20, 200, 0, 255);
        run_frame("fill", 1'b1, 1'b0);
        chk("fill_min_c0", 32'(stat_min[7:0]), 32'(20));
        chk("fill_max_c0", 32'(stat_max[7:0]), 32'(200));
        chk("fill_diff_c0", 32'(stat_diff[7:0]), 32'(180));
        fill(3, 24, 40, 200, 0, 255);
        run_frame("avg2", 1'b1, 1'b0);
        fill(3, 24, 60, 200, 0, 255);
        run_frame("avg3", 1'b1, 1'b0);
        fill(3, 24, 80, 200, 0, 255);
        run_frame("avg4", 1'b1, 1'b0);
        chk("avg4_min_c0", 32'(stat_min[7:0]), 32'(50));

        // Independent min and max update within one 3-beat line
        do_clear();
        set_cfg(0, 2, 0);
        fill(1, 3, 0, 255, 0, 255);
        pix[0][0][0] = 8'd100; pix[0][0][1] = 8'd50; pix[0][0][2] = 8'd150;
        run_frame("indep", 1'b0, 1'b0);
        chk("indep_min_c0", 32'(stat_min[7:0]), 32'(50));
        chk("indep_max_c0", 32'(stat_max[7:0]), 32'(150));

        // Window edges: outliers just outside the window are ignored
        do_clear();
        set_cfg(10, 1268, 0);
        nl = 1;
        llen[0] = 1280;
        for (int i = 0; i < 1280; i++) begin
            pix[0][0][i] = 8'd128;
            pix[1][0][i] = 8'd128;
        end
        pix[0][0][9] = 8'd0;
        pix[0][0][1269] = 8'd255;
        run_frame("edge", 1'b0, 1'b0);
        chk("edge_min_c0", 32'(stat_min[7:0]), 32'(128));
        chk("edge_max_c0", 32'(stat_max[7:0]), 32'(128));
        chk("edge_diff_c0", 32'(stat_diff[7:0]), 32'(0));

        // Clear on the final eop suppresses the update and restarts averaging
        set_cfg(1, 8, 1);
        fill(2, 10, 100, 220, 100, 220);
        run_frame("pre_clr", 1'b1, 1'b0);
        fill(2, 10, 30, 60, 30, 60);
        run_frame("clr_eop", 1'b1, 1'b1);
        fill(2, 10, 5, 9, 5, 9);
        run_frame("post_clr", 1'b1, 1'b0);
        chk("post_clr_min_c0", 32'(stat_min[7:0]), 32'(5));
        chk("post_clr_max_c0", 32'(stat_max[7:0]), 32'(9));

        // Two channels with different ranges
        do_clear();
        set_cfg(0, 15, 3);
        fill(4, 16, 10, 20, 30, 90);
        run_frame("ch2", 1'b1, 1'b0);
        chk("ch2_diff", 32'(stat_diff), 32'({8'd60, 8'd10}));

        // Empty window and lines too short: no pulse, outputs held
        set_cfg(15, 5, 1);
        fill(2, 20, 0, 255, 0, 255);
        run_frame("nowin", 1'b1, 1'b0);
        set_cfg(30, 35, 1);
        fill(2, 10, 0, 255, 0, 255);
        run_frame("short", 1'b1, 1'b0);

        // One-pixel lines (sop and eop on the same beat)
        set_cfg(0, 0, 2);
        fill(3, 1, 0, 255, 0, 255);
        run_frame("onepix", 1'b1, 1'b0);

        // Randomized frames
        for (int f = 0; f < 14; f++) begin
            int xs, xe, len, lines;
            lines = $urandom_range(MAXL, 1);
            len   = $urandom_range(40, 1);
            xs    = $urandom_range(40, 0);
            xe    = xs + $urandom_range(12, 0) - 2;
            if (xe < 0) xe = 0;
            set_cfg(xs, xe, lines - 1);
            fill(lines, len, $urandom_range(127, 0), $urandom_range(255, 128),
                 $urandom_range(127, 0), $urandom_range(255, 128));
            for (int l = 0; l < lines; l++) llen[l] = $urandom_range(len, 1);
            run_frame($sformatf("rnd%0d", f), 1'b1, ($urandom_range(0, 6) == 0));
        end

        // Reset mid-frame: next line becomes line 0 of a fresh frame
        set_cfg(0, 7, 2);
        fill(3, 8, 0, 255, 0, 255);
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 8; i++)
                beat(i == 0, i == 7, {pix[1][l][i], pix[0][l][i]}, 1'b0, 1'b0);
        idle();
        reset_n = 1'b0;
        #2;
        chk("mid_rst_min", 32'(stat_min), 32'(0));
        chk("mid_rst_max", 32'(stat_max), 32'(0));
        chk("mid_rst_diff", 32'(stat_diff), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        m_empty = 1'b1;
        e_min = '0; e_max = '0; e_diff = '0;
        @(negedge clk);
        fill(3, 8, 40, 90, 40, 90);
        run_frame("after_rst", 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
